// File: rtl/johnson_burst_sequencer.sv
// Burst controller that runs an N-stage Johnson ring for a commanded number of revolutions.
// Optional JSEQ_HOLD_EN adds a hold port that freezes the ring while running.
module johnson_burst_sequencer #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CW-1:0]   cmd_cycles,
  input  logic            abort,
`ifdef JSEQ_HOLD_EN
  input  logic            hold,
`endif
  output logic [N-1:0]    Q,
  output logic [2*N-1:0]  phase,
  output logic            phase_valid,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [CW-1:0]   rev_count
);

  localparam int IW = $clog2(2 * N) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  q_d;
  logic [CW-1:0] rev_d, tgt_q, tgt_d, rev_inc;
  logic          done_d, aborted_d, hold_eff;
  logic [IW-1:0] ones, idx;

`ifdef JSEQ_HOLD_EN
  assign hold_eff = hold;
`else
  assign hold_eff = 1'b0;
`endif

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign phase_valid = busy && !hold_eff;
  assign rev_inc     = rev_count + CW'(1);

  always_comb begin
    state_d   = state_q;
    q_d       = Q;
    rev_d     = rev_count;
    tgt_d     = tgt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tgt_d = cmd_cycles;
          rev_d = '0;
          q_d   = '0;
          if (cmd_cycles != '0) state_d = RUN;
          else                  done_d  = 1'b1;
        end
      end
      RUN: begin
        // abort takes priority over both hold and the final-revolution completion
        if (abort) begin
          q_d       = '0;
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (!hold_eff) begin
          q_d = {~Q[0], Q[N-1:1]};
          if (Q == N'(1)) begin
            rev_d = rev_inc;
            if (rev_inc == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      Q         <= '0;
      rev_count <= '0;
      tgt_q     <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state_q   <= state_d;
      Q         <= q_d;
      rev_count <= rev_d;
      tgt_q     <= tgt_d;
      done      <= done_d;
      aborted   <= aborted_d;
    end
  end

  // Ring index from population count: MSB set means filling phase (index = ones),
  // otherwise draining phase (index = 2N - ones), all-zero is index 0.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < N; i++) ones = ones + IW'(Q[i]);
    if (Q[N-1])           idx = ones;
    else if (ones == '0)  idx = '0;
    else                  idx = IW'(2 * N) - ones;
    phase = '0;
    for (int unsigned k = 0; k < 2 * N; k++) phase[k] = phase_valid && (idx == IW'(k));
  end

endmodule

// File: tb/tb_johnson_burst_sequencer.sv
// Randomized self-checking bench for johnson_burst_sequencer against a ring-index reference model.
module tb_johnson_burst_sequencer;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int P  = 2 * N;
`ifdef JSEQ_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam int VW = N + 4 + CW + P + 1;

  logic          clk = 1'b0;
  logic          clear, cmd_valid, abort, hold;
  logic [CW-1:0] cmd_cycles;
  logic          cmd_ready, phase_valid, busy, done, aborted;
  logic [N-1:0]  Q;
  logic [P-1:0]  phase;
  logic [CW-1:0] rev_count;

  int checks = 0;
  int errors = 0;

  bit            m_busy = 1'b0, m_done = 1'b0, m_abt = 1'b0;
  int            m_pos  = 0;
  logic [CW-1:0] m_rev  = '0, m_tgt = '0;

  johnson_burst_sequencer #(.N(N), .CW(CW)) dut (
    .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_cycles(cmd_cycles), .abort(abort),
`ifdef JSEQ_HOLD_EN
    .hold(hold),
`endif
    .Q(Q), .phase(phase), .phase_valid(phase_valid), .busy(busy),
    .done(done), .aborted(aborted), .rev_count(rev_count)
  );

  always #5 clk = ~clk;

  // Ring pattern for index k: 0 -> empty, 1..N -> top k bits set, N+1..2N-1 -> bottom 2N-k bits set.
  function automatic logic [N-1:0] ring_at(int k);
    if (k == 0)      return '0;
    else if (k <= N) return N'(((1 << k) - 1) << (N - k));
    else             return N'((1 << (P - k)) - 1);
  endfunction

  function automatic logic [VW-1:0] obs();
    return {Q, cmd_ready, busy, done, aborted, rev_count, phase, phase_valid};
  endfunction

  function automatic logic [VW-1:0] expv();
    bit pv;
    logic [P-1:0] ph;
    pv = m_busy && !(HOLD_EN && hold);
    ph = pv ? P'(1 << m_pos) : '0;
    return {ring_at(m_busy ? m_pos : 0), !m_busy, m_busy, m_done, m_abt, m_rev, ph, pv};
  endfunction

  task automatic step();
    bit hb;
    @(posedge clk);
    hb = HOLD_EN && hold;
    m_done = 1'b0;
    m_abt  = 1'b0;
    if (clear) begin
      m_busy = 1'b0; m_pos = 0; m_rev = '0; m_tgt = '0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_tgt = cmd_cycles;
        m_rev = '0;
        if (cmd_cycles != '0) m_busy = 1'b1;
        else                  m_done = 1'b1;
      end
    end else if (abort) begin
      m_busy = 1'b0; m_pos = 0; m_abt = 1'b1;
    end else if (!hb) begin
      m_pos = (m_pos + 1) % P;
      if (m_pos == 0) begin
        m_rev = m_rev + 1'b1;
        if (m_rev == m_tgt) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; cmd_valid = 1'b0; abort = 1'b0; hold = 1'b0; cmd_cycles = '0;
    step();
    step();
    clear = 1'b0;
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL reset: got %h expected %h", obs(), expv());
    end
    checks++;
    if (Q !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || rev_count !== '0) begin
      errors++; $display("FAIL reset_values: got Q=%b rdy=%b busy=%b done=%b abt=%b rev=%0d", Q, cmd_ready, busy, done, aborted, rev_count);
    end
  endtask

  task automatic test_burst2();
    cmd_valid = 1'b1; cmd_cycles = 8'd2;
    step();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL burst2 edge %0d: got %h expected %h", i, obs(), expv());
      end
      if (i == 16) begin
        checks++;
        if (done !== 1'b1 || rev_count !== 8'd2 || Q !== '0) begin
          errors++; $display("FAIL burst2_done: got done=%b rev=%0d Q=%b expected done=1 rev=2 Q=0000", done, rev_count, Q);
        end
      end
    end
  endtask

  task automatic test_zero();
    cmd_valid = 1'b1; cmd_cycles = 8'd0;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || Q !== '0 || obs() !== expv()) begin
      errors++; $display("FAIL zero_cmd: got %h expected %h", obs(), expv());
    end
    step();
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL zero_cmd_after: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_abort();
    int n;
    cmd_valid = 1'b1; cmd_cycles = 8'd3;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!(m_busy && m_rev == 8'd1 && m_pos == 3) && n < 40) begin
      step(); n++;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL abort_run edge %0d: got %h expected %h", n, obs(), expv());
      end
    end
    checks++;
    if (n >= 40 || Q !== 4'b1110) begin
      errors++; $display("FAIL abort_reach: got Q=%b after %0d edges expected 1110 in revolution 2", Q, n);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (Q !== '0 || aborted !== 1'b1 || done !== 1'b0 || rev_count !== 8'd1 || obs() !== expv()) begin
      errors++; $display("FAIL abort: got Q=%b abt=%b done=%b rev=%0d expected Q=0000 abt=1 done=0 rev=1", Q, aborted, done, rev_count);
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_cycles = 8'd1;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL back_to_back edge %0d: got %h expected %h", i, obs(), expv());
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 12 && m_busy; i++) step();
  endtask

`ifdef JSEQ_HOLD_EN
  task automatic test_hold();
    cmd_valid = 1'b1; cmd_cycles = 8'd1;
    step();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      hold = (e >= 3 && e <= 5);
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL hold edge %0d: got %h expected %h", e, obs(), expv());
      end
      if (e >= 3 && e <= 5) begin
        checks++;
        if (Q !== 4'b1100 || phase_valid !== 1'b0 || phase !== '0) begin
          errors++; $display("FAIL hold_freeze edge %0d: got Q=%b pv=%b phase=%b expected Q=1100 pv=0 phase=0", e, Q, phase_valid, phase);
        end
      end
      if (e == 11) begin
        checks++;
        if (done !== 1'b1) begin
          errors++; $display("FAIL hold_done: got done=%b after E11 expected 1", done);
        end
      end
    end
    hold = 1'b0;
  endtask
`endif

  task automatic test_clear_mid();
    int n;
    cmd_valid = 1'b1; cmd_cycles = 8'd2;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!(m_busy && m_pos == 5) && n < 20) begin
      step(); n++;
    end
    checks++;
    if (n >= 20 || Q !== 4'b0111) begin
      errors++; $display("FAIL clear_reach: got Q=%b expected 0111", Q);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (Q !== '0 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || obs() !== expv()) begin
        errors++; $display("FAIL clear_mid %0d: got %h expected %h", i, obs(), expv());
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cmd_valid  = ($urandom % 3) == 0;
      cmd_cycles = CW'($urandom % 4);
      abort      = ($urandom % 25) == 0;
      hold       = HOLD_EN && (($urandom % 5) == 0);
      clear      = ($urandom % 150) == 0;
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random cycle %0d: got %h expected %h", i, obs(), expv());
      end
    end
    cmd_valid = 1'b0; abort = 1'b0; hold = 1'b0; clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_burst2();
    test_zero();
    test_abort();
    test_back_to_back();
`ifdef JSEQ_HOLD_EN
    test_hold();
`endif
    test_clear_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
